get_class_stream: RTL

//  Parametrised successor of the fixed 10-way comparator tree at the end of the FC stage.

---
 rtl/get_class_pkg.sv | 20 ++
 rtl/top2_update.sv | 50 +++++
 rtl/get_class_stream.sv | 109 ++++++++++
 3 files changed

// File: rtl/get_class_pkg.sv
// Shared definitions for the streaming top-2 class selector: FSM encoding and
// index-width helpers used to size the class index ports.
package get_class_pkg;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Index outputs need at least one bit even for degenerate class counts.
  function automatic int idx_w_of(input int num_class);
    return (clog2(num_class) < 1) ? 1 : clog2(num_class);
  endfunction

endpackage

// File: rtl/top2_update.sv
// Combinational compare/update step for the best/second-best tracker.
// Strict compares keep the lower index on ties in both slots.
module top2_update #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  parameter int SIGNED = 0
) (
  input  logic [DATA_W-1:0] best_value,
  input  logic [IDX_W-1:0]  best_index,
  input  logic [DATA_W-1:0] second_value,
  input  logic [IDX_W-1:0]  second_index,
  input  logic [DATA_W-1:0] x,
  input  logic [IDX_W-1:0]  k,
  input  logic              is_first,
  input  logic              is_second,
  output logic [DATA_W-1:0] next_best_value,
  output logic [IDX_W-1:0]  next_best_index,
  output logic [DATA_W-1:0] next_second_value,
  output logic [IDX_W-1:0]  next_second_index
);

  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_best_value   = best_value;
    next_best_index   = best_index;
    next_second_value = second_value;
    next_second_index = second_index;
    if (is_first) begin
      next_best_value   = x;
      next_best_index   = k;
      next_second_value = '0;
      next_second_index = '0;
    end else if (gt(x, best_value)) begin
      next_second_value = best_value;
      next_second_index = best_index;
      next_best_value   = x;
      next_best_index   = k;
    end else if (is_second || gt(x, second_value)) begin
      // Beat 1 always fills the empty second slot when it does not take best.
      next_second_value = x;
      next_second_index = k;
    end
  end

endmodule

// File: rtl/get_class_stream.sv
// Serial top-2 class selector: collects NUM_CLASS scores over valid/ready and
// holds best/runner-up value, index and margin until the consumer accepts.
module get_class_stream
  import get_class_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int NUM_CLASS = 10,
  parameter  int SIGNED    = 0,
  localparam int IDX_W     = idx_w_of(NUM_CLASS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_value,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_value2,
  output logic [IDX_W-1:0]  out_index2,
  output logic [DATA_W:0]   out_margin
);

  logic [0:0]        state;
  logic [IDX_W-1:0]  count;
  logic [DATA_W-1:0] best_value, second_value;
  logic [IDX_W-1:0]  best_index, second_index;
  logic [DATA_W-1:0] nxt_best_value, nxt_second_value;
  logic [IDX_W-1:0]  nxt_best_index, nxt_second_index;
  logic              accept, last_beat;

  assign in_ready  = rst_n && (state == COLLECT);
  assign out_valid = rst_n && (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (count == IDX_W'(NUM_CLASS - 1));

  top2_update #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .SIGNED (SIGNED)
  ) u_update (
    .best_value        (best_value),
    .best_index        (best_index),
    .second_value      (second_value),
    .second_index      (second_index),
    .x                 (in_data),
    .k                 (count),
    .is_first          (count == '0),
    .is_second         (count == IDX_W'(1)),
    .next_best_value   (nxt_best_value),
    .next_best_index   (nxt_best_index),
    .next_second_value (nxt_second_value),
    .next_second_index (nxt_second_index)
  );

  // Sign- or zero-extend by one bit so the difference can never overflow.
  function automatic logic [DATA_W:0] ext(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) return {v[DATA_W-1], v};
    return {1'b0, v};
  endfunction

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every register here is a flop, not memory, so all are reset to defined values.
      state        <= COLLECT;
      count        <= '0;
      best_value   <= '0;
      best_index   <= '0;
      second_value <= '0;
      second_index <= '0;
      out_value    <= '0;
      out_index    <= '0;
      out_value2   <= '0;
      out_index2   <= '0;
      out_margin   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            best_value   <= nxt_best_value;
            best_index   <= nxt_best_index;
            second_value <= nxt_second_value;
            second_index <= nxt_second_index;
            if (last_beat) begin
              state      <= HOLD;
              out_value  <= nxt_best_value;
              out_index  <= nxt_best_index;
              out_value2 <= nxt_second_value;
              out_index2 <= nxt_second_index;
              out_margin <= ext(nxt_best_value) - ext(nxt_second_value);
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= COLLECT;
            count <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
